// File: rtl/shiftsub_div_pkg.sv
// Shared definitions for the shift/subtract divider: control state encoding
// and the default operand width.
package shiftsub_div_pkg;

    localparam int DEFAULT_N = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shiftsub_divider_if.sv
// Request/result bundle of the divider: operands and start from the requester,
// registered results and completion flags back from the divider.
interface shiftsub_divider_if
    import shiftsub_div_pkg::*;
#(
    parameter int N = DEFAULT_N
);

    logic         start;
    logic [N-1:0] dividend_in;
    logic [N-1:0] divisor_in;
    logic         stop;
    logic [N-1:0] quotient_out;
    logic [N-1:0] remainder_out;
    logic         div_by_zero;

    modport master (
        output start, dividend_in, divisor_in,
        input  stop, quotient_out, remainder_out, div_by_zero
    );

    modport slave (
        input  start, dividend_in, divisor_in,
        output stop, quotient_out, remainder_out, div_by_zero
    );

endinterface

// File: rtl/shiftsub_div_datapath.sv
// Restoring-division datapath: partial remainder, quotient/dividend shift
// register and divisor, plus the combinational result of one step.
module shiftsub_div_datapath
    import shiftsub_div_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         step,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] q_step,
    output logic [N-1:0] r_step
);

    // The partial remainder is always below the divisor between steps, so its
    // top bit is zero; only the shifted value needs the full N+1 bits.
    logic [N-1:0] r;
    logic [N-1:0] q;
    logic [N-1:0] d;
    logic [N:0]   r_shift;
    logic [N-1:0] r_diff;
    logic         ge;

    always_comb begin
        r_shift = {r, q[N-1]};
        ge      = (r_shift >= {1'b0, d});
        r_diff  = r_shift[N-1:0] - d;
        r_step  = ge ? r_diff : r_shift[N-1:0];
        q_step  = (q << 1) | N'(ge);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r <= '0;
            q <= '0;
            d <= '0;
        end else if (load) begin
            r <= '0;
            q <= dividend;
            d <= divisor;
        end else if (step) begin
            r <= r_step;
            q <= q_step;
        end
    end

endmodule

// File: rtl/shiftsub_divider.sv
// N-bit unsigned restoring divider: one quotient bit per clock, results
// registered on entry to DONE, divide-by-zero resolved on the accepting edge.
module shiftsub_divider
    import shiftsub_div_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic               clk,
    input  logic               reset,
    shiftsub_divider_if.slave  bus
);

    localparam int CW = $clog2(N + 1);

    state_t       state;
    state_t       next_state;
    logic [CW-1:0] cnt;
    logic         load;
    logic         step;
    logic         capture;
    logic         zero_div;
    logic         last_step;
    logic [N-1:0] q_step;
    logic [N-1:0] r_step;

    shiftsub_div_datapath #(.N(N)) u_datapath (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .step     (step),
        .dividend (bus.dividend_in),
        .divisor  (bus.divisor_in),
        .q_step   (q_step),
        .r_step   (r_step)
    );

    assign last_step = (cnt == CW'(N - 1));

    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        capture    = 1'b0;
        zero_div   = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    load = 1'b1;
                    if (bus.divisor_in == '0) begin
                        zero_div   = 1'b1;
                        next_state = DONE;
                    end else begin
                        next_state = CALC;
                    end
                end
            end
            CALC: begin
                step = 1'b1;
                if (last_step) begin
                    capture    = 1'b1;
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state             <= IDLE;
            cnt               <= '0;
            bus.stop          <= 1'b0;
            bus.quotient_out  <= '0;
            bus.remainder_out <= '0;
            bus.div_by_zero   <= 1'b0;
        end else begin
            state    <= next_state;
            bus.stop <= (next_state == DONE);
            if (load) begin
                cnt <= '0;
            end else if (step) begin
                cnt <= cnt + CW'(1);
            end
            // Results move only when DONE is entered; they hold through CALC.
            if (capture) begin
                bus.quotient_out  <= q_step;
                bus.remainder_out <= r_step;
                bus.div_by_zero   <= 1'b0;
            end else if (zero_div) begin
                bus.quotient_out  <= '1;
                bus.remainder_out <= bus.dividend_in;
                bus.div_by_zero   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_shiftsub_divider.sv
// Self-checking bench for shiftsub_divider: arithmetic reference model checked
// every cycle, plus directed cases with literal expected results.
module tb_shiftsub_divider;

    localparam int N = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    shiftsub_divider_if #(.N(N)) bus ();

    shiftsub_divider #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: results are plain / and %, available N edges after
    // acceptance (or on the accepting edge itself for a zero divisor).
    logic         m_on = 1'b0;
    logic         m_stop;
    logic [N-1:0] m_q;
    logic [N-1:0] m_r;
    logic         m_dbz;
    logic [N-1:0] p_q;
    logic [N-1:0] p_r;
    int           m_wait;

    always @(posedge clk) begin
        if (!reset) begin
            m_on   <= 1'b1;
            m_stop <= 1'b0;
            m_q    <= '0;
            m_r    <= '0;
            m_dbz  <= 1'b0;
            m_wait <= 0;
        end else if (m_wait > 0) begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) begin
                m_stop <= 1'b1;
                m_q    <= p_q;
                m_r    <= p_r;
                m_dbz  <= 1'b0;
            end
        end else if (bus.start) begin
            if (bus.divisor_in == '0) begin
                m_stop <= 1'b1;
                m_q    <= '1;
                m_r    <= bus.dividend_in;
                m_dbz  <= 1'b1;
            end else begin
                m_stop <= 1'b0;
                p_q    <= bus.dividend_in / bus.divisor_in;
                p_r    <= bus.dividend_in % bus.divisor_in;
                m_wait <= N;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input bit rnd, output int lat);
        bus.dividend_in = a;
        bus.divisor_in  = b;
        bus.start       = 1'b1;
        @(posedge clk);
        #1;
        lat       = 1;
        bus.start = 1'b0;
        while (!bus.stop && lat < 64) begin
            if (rnd) begin
                bus.start       = 1'($urandom_range(0, 1));
                bus.dividend_in = N'($urandom);
                bus.divisor_in  = N'($urandom);
            end
            @(posedge clk);
            #1;
            lat++;
        end
        bus.start = 1'b0;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [N-1:0] a;
        logic [N-1:0] b;

        fork
            forever begin
                @(negedge clk);
                if (m_on) begin
                    tests++;
                    if ({bus.stop, bus.quotient_out, bus.remainder_out, bus.div_by_zero}
                        !== {m_stop, m_q, m_r, m_dbz}) begin
                        fails++;
                        $display("FAIL cycle_model @%0t: stop=%0b q=%0d r=%0d dbz=%0b, expected stop=%0b q=%0d r=%0d dbz=%0b",
                                 $time, bus.stop, bus.quotient_out, bus.remainder_out, bus.div_by_zero,
                                 m_stop, m_q, m_r, m_dbz);
                    end
                end
            end
        join_none

        bus.start       = 1'b0;
        bus.dividend_in = '0;
        bus.divisor_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_stop", int'(bus.stop), 0);
        check("reset_q", int'(bus.quotient_out), 0);
        check("reset_r", int'(bus.remainder_out), 0);
        check("reset_dbz", int'(bus.div_by_zero), 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run_op(8'd100, 8'd7, 1'b0, lat);
        check("lat_100_7", lat, 9);
        check("q_100_7", int'(bus.quotient_out), 14);
        check("r_100_7", int'(bus.remainder_out), 2);
        check("dbz_100_7", int'(bus.div_by_zero), 0);
        check("model_q_100_7", int'(m_q), 14);
        repeat (3) @(posedge clk);
        #1;
        check("hold_stop", int'(bus.stop), 1);
        check("hold_q", int'(bus.quotient_out), 14);

        run_op(8'd255, 8'd1, 1'b0, lat);
        check("q_255_1", int'(bus.quotient_out), 255);
        check("r_255_1", int'(bus.remainder_out), 0);
        run_op(8'd3, 8'd200, 1'b0, lat);
        check("q_3_200", int'(bus.quotient_out), 0);
        check("r_3_200", int'(bus.remainder_out), 3);

        run_op(8'd5, 8'd0, 1'b0, lat);
        check("lat_div0", lat, 1);
        check("q_div0", int'(bus.quotient_out), 255);
        check("r_div0", int'(bus.remainder_out), 5);
        check("dbz_div0", int'(bus.div_by_zero), 1);
        check("model_r_div0", int'(m_r), 5);

        // Reset partway through CALC: no partial result may appear.
        bus.dividend_in = 8'd200;
        bus.divisor_in  = 8'd9;
        bus.start       = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("abort_stop", int'(bus.stop), 0);
        check("abort_q", int'(bus.quotient_out), 0);
        check("abort_r", int'(bus.remainder_out), 0);
        check("abort_dbz", int'(bus.div_by_zero), 0);
        reset = 1'b1;
        run_op(8'd50, 8'd5, 1'b0, lat);
        check("lat_50_5", lat, 9);
        check("q_50_5", int'(bus.quotient_out), 10);
        check("r_50_5", int'(bus.remainder_out), 0);

        // start held high across two back-to-back divisions.
        bus.dividend_in = 8'd200;
        bus.divisor_in  = 8'd9;
        bus.start       = 1'b1;
        @(posedge clk);
        #1;
        lat = 1;
        while (!bus.stop && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("held_lat1", lat, 9);
        check("held_q1", int'(bus.quotient_out), 22);
        check("held_r1", int'(bus.remainder_out), 2);
        bus.dividend_in = 8'd17;
        bus.divisor_in  = 8'd4;
        @(posedge clk);
        #1;
        check("held_stop_drop", int'(bus.stop), 0);
        lat = 1;
        while (!bus.stop && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("held_lat2", lat, 9);
        check("held_q2", int'(bus.quotient_out), 4);
        check("held_r2", int'(bus.remainder_out), 1);
        bus.start = 1'b0;
        @(posedge clk);
        #1;

        // Random sweep with operand/start noise during CALC.
        for (int i = 0; i < 3000; i++) begin
            a = N'($urandom);
            b = ($urandom_range(0, 15) == 0) ? '0 : N'($urandom);
            run_op(a, b, 1'b1, lat);
            if (b == '0) begin
                check("rnd_lat_div0", lat, 1);
                check("rnd_dbz", int'(bus.div_by_zero), 1);
            end else begin
                check("rnd_lat", lat, N + 1);
                check("rnd_identity",
                      int'(bus.quotient_out) * int'(b) + int'(bus.remainder_out), int'(a));
                check("rnd_rem_lt_div", int'(bus.remainder_out < b), 1);
            end
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
